mult_rescale: RTL and testbench



---
 rtl/mult_rescale_pkg.sv | 23 ++
 rtl/mult_rescale_if.sv | 29 ++
 rtl/mult_rescale_sat_clip.sv | 32 +++
 rtl/mult_rescale.sv | 109 ++++++++++
 tb/tb_mult_rescale.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_rescale_pkg.sv
// Shared defaults and helpers for the multiplier rescale stage (package mult_pkg).
package mult_pkg;

    localparam int unsigned DEF_WIDTH     = 64;
    localparam int unsigned DEF_OUT_WIDTH = 32;
    localparam int unsigned DEF_SHIFT_W   = 7;

    // Bounds are computed at a fixed wide width so any IN_W/OUT_W up to MAX_W-1 compares correctly
    localparam int unsigned MAX_W = 128;

    function automatic logic signed [MAX_W-1:0] sat_max(input int unsigned out_w);
        return (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_min(input int unsigned out_w);
        return -(MAX_W'(1) << (out_w - 1));
    endfunction

    function automatic int unsigned clamp_shift(input int unsigned sh, input int unsigned width);
        return (sh > width - 1) ? width - 1 : sh;
    endfunction

endpackage

// File: rtl/mult_rescale_if.sv
// Valid/ready bus between the multiplier, the rescale stage and its consumer.
interface mult_rescale_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned SHIFT_W   = DEF_SHIFT_W
) ();

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     in_data_i;
    logic [SHIFT_W-1:0]   in_shift_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OUT_WIDTH-1:0] out_data_o;
    logic                 out_sat_o;

    modport master (
        output in_valid_i, in_data_i, in_shift_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_sat_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_shift_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_sat_o
    );

endinterface

// File: rtl/mult_rescale_sat_clip.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits with a clip flag.
module sat_clip
    import mult_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_WIDTH + 1,
    parameter int unsigned OUT_W = DEF_OUT_WIDTH
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    localparam logic signed [MAX_W-1:0] HI = sat_max(OUT_W);
    localparam logic signed [MAX_W-1:0] LO = sat_min(OUT_W);

    logic signed [MAX_W-1:0] ext;

    assign ext = $signed({{(MAX_W - IN_W){din[IN_W-1]}}, din});

    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (ext > HI) begin
            dout = HI[OUT_W-1:0];
            sat  = 1'b1;
        end else if (ext < LO) begin
            dout = LO[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/mult_rescale.sv
// Two-stage round/shift then saturate pipeline behind the multiplier.
// Optional saturation event counter enabled by `define MULT_RESCALE_SAT_CNT_EN.
module mult_rescale
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned SHIFT_W   = DEF_SHIFT_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mult_rescale_if.slave bus
`ifdef MULT_RESCALE_SAT_CNT_EN
    ,
    input  logic          sat_cnt_clr_i,
    output logic [31:0]   sat_cnt_o
`endif
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic                 s1_valid;
    logic signed [WIDTH:0] s1_data;
    logic                 s2_valid;
    logic [OUT_WIDTH-1:0] s2_data;
    logic                 s2_sat;

    logic                 s2_can_load;
    logic                 in_ready;

    logic [SHIFT_W-1:0]   shift_raw;
    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       bias;
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] rnd;
    logic signed [WIDTH:0] shifted;

    logic [OUT_WIDTH-1:0] clip_data;
    logic                 clip_sat;

    assign s2_can_load = !s2_valid || bus.out_ready_i;
    assign in_ready    = !s1_valid || s2_can_load;

    assign shift_raw = bus.in_shift_i;
    assign sh        = SHW'(clamp_shift(32'(shift_raw), WIDTH));

    // One extra bit of headroom so adding the half-LSB bias can never overflow
    always_comb begin
        ext     = $signed({bus.in_data_i[WIDTH-1], bus.in_data_i});
        bias    = (sh == '0) ? '0 : ((WIDTH + 1)'(1) << (sh - 1'b1));
        rnd     = ext + $signed(bias);
        shifted = rnd >>> sh;
    end

    sat_clip #(
        .IN_W  (WIDTH + 1),
        .OUT_W (OUT_WIDTH)
    ) u_sat_clip (
        .din  (s1_data),
        .dout (clip_data),
        .sat  (clip_sat)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    s1_data <= shifted;
                end
            end
            if (s2_can_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= clip_data;
                    s2_sat  <= clip_sat;
                end
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid;
    assign bus.out_data_o  = s2_data;
    assign bus.out_sat_o   = s2_sat;

`ifdef MULT_RESCALE_SAT_CNT_EN
    logic [31:0] sat_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt <= '0;
        end else if (sat_cnt_clr_i) begin
            sat_cnt <= '0;
        end else if (s2_valid && bus.out_ready_i && s2_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 32'd1;
        end
    end

    assign sat_cnt_o = sat_cnt;
`endif

endmodule

// File: tb/tb_mult_rescale.sv
// Self-checking bench for mult_rescale: directed table, backpressure, streaming, reset mid-flight.
module tb_mult_rescale;

    logic clk;
    logic rst_n;

    mult_rescale_if #(.WIDTH(64), .OUT_WIDTH(32), .SHIFT_W(7)) bus ();

`ifdef MULT_RESCALE_SAT_CNT_EN
    logic        sat_cnt_clr;
    logic [31:0] sat_cnt;
`endif

    mult_rescale #(.WIDTH(64), .OUT_WIDTH(32), .SHIFT_W(7)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef MULT_RESCALE_SAT_CNT_EN
        ,
        .sat_cnt_clr_i (sat_cnt_clr),
        .sat_cnt_o     (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: y = floor(x / 2^sh + 1/2), then clip to the signed 32-bit range
    function automatic void ref_model(input logic signed [63:0] x, input int unsigned shift,
                                      output logic [31:0] y, output bit sat);
        int unsigned sh;
        logic signed [127:0] num, den, q;
        sh  = (shift > 63) ? 63 : shift;
        den = 128'sd1 <<< (sh + 1);
        num = x;
        num = num * 128'sd2 + (den >>> 1);
        q   = num / den;
        if ((num % den) != 0 && num < 0) q = q - 128'sd1;
        if (q > 128'sd2147483647) begin
            y = 32'h7FFFFFFF; sat = 1'b1;
        end else if (q < -128'sd2147483648) begin
            y = 32'h80000000; sat = 1'b1;
        end else begin
            y = q[31:0]; sat = 1'b0;
        end
    endfunction

    typedef struct {
        logic [31:0] d;
        bit          s;
    } exp_t;

    exp_t exp_q[$];

    // Scoreboard: every accepted input must come out, in order, with model value
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_out", 64'(bus.out_data_o), 64'hDEAD);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_data", 64'(bus.out_data_o), 64'(e.d));
                        chk("sb_sat", 64'(bus.out_sat_o), 64'(e.s));
                    end
                end
                if (bus.in_valid_i && bus.in_ready_o) begin
                    exp_t e;
                    ref_model($signed(bus.in_data_i), 32'(bus.in_shift_i), e.d, e.s);
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic signed [63:0] din;
        logic [6:0]         sh;
        logic [31:0]        exp;
        bit                 sat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] s_exp[100];
        bit          s_sat[100];
        logic [31:0] got[$];
        int          accepted;
        int          cur;

        tbl[0] = '{64'sd384,  7'd8,   32'd2,          1'b0};
        tbl[1] = '{-64'sd384, 7'd8,   32'hFFFFFFFF,   1'b0};
        tbl[2] = '{-64'sd640, 7'd8,   32'hFFFFFFFE,   1'b0};
        tbl[3] = '{64'sd383,  7'd8,   32'd1,          1'b0};
        tbl[4] = '{-64'sd5,   7'd0,   32'hFFFFFFFB,   1'b0};
        tbl[5] = '{64'sd4611686018427387904, 7'd100, 32'd1, 1'b0};
        tbl[6] = '{64'h8000000000000000,     7'd63,  32'hFFFFFFFF, 1'b0};
        tbl[7] = '{64'sd1099511627776,       7'd0,   32'h7FFFFFFF, 1'b1};
        tbl[8] = '{-64'sd1099511627776,      7'd0,   32'h80000000, 1'b1};
        tbl[9] = '{64'sd140737488355328,     7'd16,  32'h7FFFFFFF, 1'b1};

        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.in_shift_i  = '0;
        bus.out_ready_i = 1'b1;
`ifdef MULT_RESCALE_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_out_data", 64'(bus.out_data_o), 64'd0);
        chk("rst_out_sat", 64'(bus.out_sat_o), 64'd0);
`ifdef MULT_RESCALE_SAT_CNT_EN
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Directed vectors, one at a time, checking exact 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = tbl[i].din;
            bus.in_shift_i = tbl[i].sh;
            tick();
            bus.in_valid_i = 1'b0;
            chk($sformatf("tbl%0d_not_early", i), 64'(bus.out_valid_o), 64'd0);
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid_o), 64'd1);
            chk($sformatf("tbl%0d_data", i), 64'(bus.out_data_o), 64'(tbl[i].exp));
            chk($sformatf("tbl%0d_sat", i), 64'(bus.out_sat_o), 64'(tbl[i].sat));
        end
        tick();
        chk("tbl_drained", 64'(bus.out_valid_o), 64'd0);
`ifdef MULT_RESCALE_SAT_CNT_EN
        chk("tbl_sat_cnt", 64'(sat_cnt), 64'd3);
`endif

        // Backpressure: offer 1,2,3 with the consumer stalled for 6 cycles
        bus.out_ready_i = 1'b0;
        bus.in_shift_i  = '0;
        accepted = 0;
        cur = 1;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 64'(cur);
            #1;
            if (bus.in_ready_o) begin
                accepted++;
                cur++;
            end
            tick();
        end
        #1;
        chk("bp_accepted", 64'(accepted), 64'd2);
        chk("bp_in_ready_low", 64'(bus.in_ready_o), 64'd0);
        chk("bp_head_held", 64'(bus.out_data_o), 64'd1);
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            bus.in_valid_i = (cur <= 3);
            bus.in_data_i  = 64'(cur);
            #1;
            if (bus.in_valid_i && bus.in_ready_o) cur++;
            if (bus.out_valid_o) got.push_back(bus.out_data_o);
            tick();
        end
        bus.in_valid_i = 1'b0;
        chk("bp_out_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size() && i < 3; i++) begin
            chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i + 1));
        end
        tick();
        tick();
        tick();

        // Full-throughput random streaming
        for (int c = 0; c <= 100; c++) begin
            if (c < 100) begin
                logic signed [63:0] d;
                int unsigned sh;
                d  = $signed({$urandom, $urandom}) >>> $urandom_range(0, 63);
                sh = ($urandom_range(0, 3) == 0) ? $urandom_range(64, 127) : $urandom_range(0, 40);
                ref_model(d, sh, s_exp[c], s_sat[c]);
                bus.in_valid_i = 1'b1;
                bus.in_data_i  = d;
                bus.in_shift_i = 7'(sh);
                #1;
                chk($sformatf("st%0d_in_ready", c), 64'(bus.in_ready_o), 64'd1);
            end else begin
                bus.in_valid_i = 1'b0;
            end
            tick();
            if (c >= 1) begin
                chk($sformatf("st%0d_valid", c - 1), 64'(bus.out_valid_o), 64'd1);
                chk($sformatf("st%0d_data", c - 1), 64'(bus.out_data_o), 64'(s_exp[c - 1]));
                chk($sformatf("st%0d_sat", c - 1), 64'(bus.out_sat_o), 64'(s_sat[c - 1]));
            end
        end
        tick();
        chk("st_drained", 64'(bus.out_valid_o), 64'd0);

        // Reset with two saturating samples in flight
        bus.in_shift_i = '0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'sd1099511627776;
        tick();
        bus.in_data_i  = -64'sd1099511627776;
        tick();
        bus.in_valid_i = 1'b0;
        chk("rmf_before_valid", 64'(bus.out_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmf_valid_drop", 64'(bus.out_valid_o), 64'd0);
        chk("rmf_data_zero", 64'(bus.out_data_o), 64'd0);
        chk("rmf_sat_zero", 64'(bus.out_sat_o), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
`ifdef MULT_RESCALE_SAT_CNT_EN
        chk("rmf_sat_cnt_zero", 64'(sat_cnt), 64'd0);
`endif
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rmf_no_stale%0d", c), 64'(bus.out_valid_o), 64'd0);
        end

`ifdef MULT_RESCALE_SAT_CNT_EN
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'sd1099511627776;
        tick();
        bus.in_data_i  = -64'sd1099511627776;
        tick();
        bus.in_valid_i = 1'b0;
        tick();
        tick();
        tick();
        chk("cnt_two_sat", 64'(sat_cnt), 64'd2);
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        chk("cnt_clear", 64'(sat_cnt), 64'd0);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'sd1099511627776;
        tick();
        bus.in_valid_i = 1'b0;
        tick();
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        chk("cnt_clr_priority", 64'(sat_cnt), 64'd0);
        tick();
        chk("cnt_hold", 64'(sat_cnt), 64'd0);
`endif

        tick();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
